// File: rtl/serial_feeder_pkg.sv
// ---------------------------------------------------------------------------
// serial_feeder_pkg
// Shared definitions for the serial bit feeder and its word FIFO:
//   - default WIDTH / DEPTH constants
//   - feeder_state_t FSM state enum with fixed encodings
//   - even_parity() helper used when SERIAL_FEEDER_PARITY_EN is defined
// ---------------------------------------------------------------------------
package serial_feeder_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_DEPTH    = 4;

    // Widest word the parity helper accepts; callers zero-extend into it,
    // which leaves the XOR unchanged.
    localparam int PARITY_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } feeder_state_t;

    // Even parity bit: 1 when the word holds an odd number of ones, so the
    // word plus this bit always carries an even count.
    function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_bit_feeder_fifo.sv
// ---------------------------------------------------------------------------
// feeder_word_fifo
// Small word FIFO buffering parallel words ahead of the serialiser.
// Read data is presented combinationally at the read pointer.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, pop     write / read requests (ignored when full / empty)
//   wr_data       word to store
//   rd_data       word at the head of the FIFO
//   full, empty   occupancy flags
//   wr_ptr,rd_ptr pointers (wrap naturally, DEPTH is a power of two)
//   count         words held, 0..DEPTH
// ---------------------------------------------------------------------------
module feeder_word_fifo
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage has no reset: contents are only observable through count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap by plain overflow; a simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder
// Accepts parallel words over valid/ready, buffers them in feeder_word_fifo
// and emits them MSB-first as a gap-free one-bit-per-clock stream on i.
// Drives i low while idle.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN -- appends one even-parity
// bit (carrying last) after every word.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   in_data holds a word
//   in_ready   a word can be accepted this cycle
//   in_data    parallel word
//   i          serial bit (registered)
//   bit_valid  i carries a data/parity bit (registered)
//   last       final bit of the current word (registered)
//   busy       FIFO non-empty or a word is being shifted (registered)
// ---------------------------------------------------------------------------
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             i,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int BITCNT_W = $clog2(WIDTH);

    feeder_state_t        state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic                 i_q, i_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 push;
    logic                 pop;
    logic                 load;
    logic                 full;
    logic                 empty;
    logic [WIDTH-1:0]     rd_data;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [2*PTR_W-1:0]   unused_ptrs;

    // A pop never frees a slot for a push in the same cycle: ready only
    // looks at the registered full flag.
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = load;

    // Pointers are exposed by the FIFO for debug only.
    assign unused_ptrs = {wr_ptr, rd_ptr};

    feeder_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count)
    );

    // State, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            i_q      <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            i_q      <= i_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state and next-output logic. bitcnt counts the bits still to be
    // emitted after the one currently on i; at zero the word is finished and
    // the FSM either emits parity, reloads from the FIFO with no gap, or
    // returns to IDLE. The outputs default to an idle (all-zero) cycle so i
    // is forced low whenever bit_valid is low.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        i_d      = 1'b0;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        load     = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                load = !empty;
            end
            SHIFT: begin
                if (bitcnt_q != '0) begin
                    i_d      = shift_q[WIDTH-1];
                    valid_d  = 1'b1;
                    shift_d  = shift_q << 1;
                    bitcnt_d = bitcnt_q - BITCNT_W'(1);
`ifdef SERIAL_FEEDER_PARITY_EN
                    last_d   = 1'b0;
`else
                    last_d   = (bitcnt_q == BITCNT_W'(1));
`endif
                end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
                    state_d = PARITY;
                    i_d     = parity_q;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
`else
                    load    = !empty;
                    state_d = IDLE;
`endif
                end
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            PARITY: begin
                load    = !empty;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading a word overrides whatever the state chose above.
        if (load) begin
            state_d  = SHIFT;
            i_d      = rd_data[WIDTH-1];
            valid_d  = 1'b1;
            last_d   = 1'b0;
            shift_d  = rd_data << 1;
            bitcnt_d = BITCNT_W'(WIDTH - 1);
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_d = even_parity(PARITY_MAX_WIDTH'(rd_data));
`endif
        end

        // Busy after this edge: FSM still active, or the FIFO will still
        // hold a word once this cycle's push and pop are applied.
        busy_d = (state_d != IDLE) || push || (count > CNT_W'(1))
                 || ((count != '0) && !pop);
    end

    assign i         = i_q;
    assign bit_valid = valid_q;
    assign last      = last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_feeder
// Scoreboard bench for serial_bit_feeder. Accepted words push their expected
// bit stream into a queue; a monitor pops it whenever bit_valid is high.
// A word-level timing model (accept edge, load edge) predicts in_ready,
// busy and bit_valid every cycle. Honours SERIAL_FEEDER_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_serial_bit_feeder;

    localparam int W = 8;
    localparam int D = 4;
`ifdef SERIAL_FEEDER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int BPW = W + (PAR_EN ? 1 : 0);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         i;
    logic         bit_valid;
    logic         last;
    logic         busy;

    serial_bit_feeder #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .i         (i),
        .bit_valid (bit_valid),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard of expected bits, and per-word accept/load edges.
    logic exp_bit_q[$];
    logic exp_last_q[$];
    int   acc_a[$];
    int   load_a[$];
    int   last_load = -1000;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic clearModel();
        exp_bit_q.delete();
        exp_last_q.delete();
        acc_a.delete();
        load_a.delete();
        last_load = -1000;
    endtask

    // A word is loaded on the edge after it is accepted, or as soon as the
    // previous word has used up its BPW cycles, whichever is later.
    task automatic recordWord(input logic [W-1:0] word, input int acc);
        int ld;
        for (int b = W - 1; b >= 0; b--) begin
            exp_bit_q.push_back(word[b]);
            exp_last_q.push_back((b == 0) && !PAR_EN);
        end
        if (PAR_EN) begin
            exp_bit_q.push_back(^word);
            exp_last_q.push_back(1'b1);
        end
        ld = (acc + 1 > last_load + BPW) ? acc + 1 : last_load + BPW;
        acc_a.push_back(acc);
        load_a.push_back(ld);
        last_load = ld;
    endtask

    // Called just after a falling edge; holds in_valid until accepted.
    task automatic applyStimulus(input logic [W-1:0] word);
        bit done = 1'b0;
        in_data  = word;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            if (in_ready) begin
                recordWord(word, cyc + 1);
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", done, 1'b1);
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 400; t++) begin
            if (exp_bit_q.size() == 0 && cyc > last_load + BPW) break;
            @(negedge clk);
        end
        checkOutput("drain_empty", exp_bit_q.size() == 0, 1'b1);
    endtask

    // Monitor: compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        int   occ;
        bit   active;
        logic eb;
        logic el;
        if (!rst) begin
            occ    = 0;
            active = 1'b0;
            foreach (acc_a[k]) begin
                if (acc_a[k] <= cyc) occ++;
                if (load_a[k] <= cyc) occ--;
                if (load_a[k] <= cyc && cyc < load_a[k] + BPW) active = 1'b1;
            end
            checkOutput("in_ready", in_ready, occ < D);
            checkOutput("busy", busy, (occ > 0) || active);
            checkOutput("bit_valid", bit_valid, active);
            if (bit_valid) begin
                if (exp_bit_q.size() == 0) begin
                    checkOutput("spurious_bit", 1'b1, 1'b0);
                end else begin
                    eb = exp_bit_q.pop_front();
                    el = exp_last_q.pop_front();
                    checkOutput("i", i, eb);
                    checkOutput("last", last, el);
                end
            end else begin
                checkOutput("idle_i", i, 1'b0);
                checkOutput("idle_last", last, 1'b0);
            end
        end
    end

    logic [W-1:0] six_words [6] = '{8'h3C, 8'h81, 8'h5A, 8'hE7, 8'h12, 8'h07};

    initial begin
        // Power-on reset, checked asynchronously before any clock edge.
        #1 rst = 1'b1;
        clearModel();
        #1;
        checkOutput("rst_i", i, 1'b0);
        checkOutput("rst_bit_valid", bit_valid, 1'b0);
        checkOutput("rst_last", last, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        $display("[TB] single word A5");
        applyStimulus(8'hA5);
        waitDrain();

        $display("[TB] idle 10 cycles");
        repeat (10) @(negedge clk);

        $display("[TB] FF then 00 back to back");
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        waitDrain();

        $display("[TB] six words held valid, FIFO fills and wraps");
        foreach (six_words[k]) applyStimulus(six_words[k]);
        waitDrain();

        $display("[TB] reset on third bit of C3");
        applyStimulus(8'hC3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        clearModel();
        #1;
        checkOutput("midrst_i", i, 1'b0);
        checkOutput("midrst_bit_valid", bit_valid, 1'b0);
        checkOutput("midrst_last", last, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] randomized words and gaps");
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            applyStimulus(W'($urandom));
        end
        waitDrain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
